myo_spi_poller: RTL and testbench
=================================

MYO_SPI_POLLER -- requirements
Module: myo_spi_poller

Interface
REQ-001 SHALL have parameter NUMBER_OF_MOTORS, default 9, meaning slave-select count (one motor board per ss_n bit).
REQ-002 SHALL have parameter WORD_WIDTH, default 16, meaning SPI word length in bits.
REQ-003 SHALL have parameter WORDS_PER_FRAME, default 12, meaning words exchanged per slave selection.
REQ-004 SHALL have parameter CLK_DIV, default 8, meaning sck half-period in clock cycles (>=2).
REQ-005 SHALL have parameter GAP_CYCLES, default 16, meaning idle clocks with all ss_n high between frames.
REQ-006 SHALL have ports: clock in 1 system clock; reset in 1 asynchronous active-high reset (one clock; reset is asynchronous and active-high).
REQ-007 SHALL have ports: enable in 1 polling run request; motor_mask in NUMBER_OF_MOTORS per-motor poll enable; power_sense_n in 1 low = motor power present.
REQ-008 SHALL have ports: tx_req out 1 word-request pulse; tx_motor out clog2(NUMBER_OF_MOTORS) and tx_idx out clog2(WORDS_PER_FRAME) request address; tx_word in WORD_WIDTH word for that address.
REQ-009 SHALL have ports: rx_valid out 1; rx_word out WORD_WIDTH; rx_motor, rx_idx out (same widths as tx) received-word address.
REQ-010 SHALL have ports: frame_done out 1 pulse; busy out 1; power_fault out 1; sck out 1; mosi out 1; miso in 1; ss_n out NUMBER_OF_MOTORS active-low selects.

Function
REQ-011 SHALL implement states IDLE, SELECT, LOAD, SHIFT, DESELECT, GAP.
REQ-012 IDLE -> SELECT when enable=1, power_sense_n=0 and motor_mask nonzero; else stay IDLE, busy=0.
REQ-013 Motor choice SHALL be round-robin: next set mask bit strictly above the last polled motor, wrapping to bit 0; first selection after reset starts at bit 0; mask sampled at each selection.
REQ-014 SELECT: drive ss_n[motor]=0 (all others 1), hold CLK_DIV cycles, then LOAD.
REQ-015 LOAD: pulse tx_req one cycle with tx_motor/tx_idx; capture tx_word exactly one cycle later into the shift register; then SHIFT.
REQ-016 SHIFT: SPI mode 0 (CPOL=0, CPHA=0), MSB first; mosi changes only while sck low; miso sampled on sck rising edge; WORD_WIDTH sck pulses of 2*CLK_DIV clocks.
REQ-017 After the last falling edge of a word: rx_valid pulses one cycle with rx_word, rx_motor, rx_idx; if tx_idx < WORDS_PER_FRAME-1 increment and go LOAD, else DESELECT.
REQ-018 DESELECT: hold sck=0 CLK_DIV cycles, release ss_n to all ones, pulse frame_done one cycle, go GAP.
REQ-019 GAP: count GAP_CYCLES then return to IDLE (re-evaluating REQ-012); back-to-back frames thus occur with no extra delay.
REQ-020 enable or power_sense_n changing mid-frame SHALL NOT abort the frame; the current frame completes, then REQ-012 applies.
REQ-021 power_fault SHALL be registered power_sense_n, updated every cycle, independent of state.
REQ-022 busy=1 in every state except IDLE.
REQ-023 Counters SHALL be sized by clog2 of their parameter; no counter overflows beyond its terminal value.

Reset
REQ-024 On reset assertion, immediately: ss_n all ones, sck=0, mosi=0, tx_req=0, rx_valid=0, frame_done=0, busy=0, power_fault=0, rx_word=0, state IDLE, round-robin pointer to "before bit 0".
REQ-025 Reset mid-frame SHALL abandon the frame with no rx_valid or frame_done emitted.

Structure
REQ-026 State enum and clog2-derived width constants SHALL live in shared package myo_spi_pkg.
REQ-027 The bit-level shifter (sck generation, shift, sample) SHALL be sub-module myo_spi_shifter, started by the FSM and returning a done pulse.

Verification
REQ-028 N=4, W=16, F=2, CLK_DIV=2, mask=4'b1111, tx_word=16'hA5C3, miso looped to mosi -> ss_n sequence 1110,1101,1011,0111,1110; every rx_word=16'hA5C3; 8 rx_valid per round.
REQ-029 mask=4'b0101 -> only motors 0 and 2 selected, alternating; mask=0 -> busy stays 0, ss_n=4'b1111.
REQ-030 miso tied 1 -> rx_word=16'hFFFF; tied 0 -> 16'h0000; sck period exactly 4 clocks, 16 rising edges per word.
REQ-031 enable dropped during word 0 of motor 1 -> word 1 still completes, frame_done pulses, then IDLE with ss_n all ones.
REQ-032 power_sense_n=1 before start -> no selection, power_fault=1 one cycle later; deassert -> polling starts at motor 0.
REQ-033 reset asserted mid-SHIFT -> same cycle ss_n=4'b1111, sck=0; no rx_valid; after release first frame targets motor 0.

Source files
------------

// File: rtl/myo_spi_pkg.sv
// Shared definitions for the motor-board SPI poller: controller states and the
// helper that sizes counters and address fields from their parameters.
package myo_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LOAD,
        SHIFT,
        DESELECT,
        GAP
    } state_t;

    // Never returns zero, so a parameter of 1 still produces a usable field.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_MOTOR_W = width_of(9);
    localparam int DEFAULT_IDX_W   = width_of(12);

endpackage

// File: rtl/myo_spi_shifter.sv
// Bit-level SPI mode-0 engine. It shifts one MSB-first word per start pulse and
// pulses done after the last falling edge of sck.
module myo_spi_shifter
    import myo_spi_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int CLK_DIV    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  miso,
    output logic                  sck,
    output logic                  mosi,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] data_out
);

    localparam int DIV_W = width_of(CLK_DIV);
    localparam int BIT_W = width_of(WORD_WIDTH);

    logic                  active;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [WORD_WIDTH-1:0] tx_shift;
    logic [WORD_WIDTH-1:0] rx_shift;

    // mosi only moves on load or on a falling sck edge, so it is stable across every rising edge
    assign mosi = tx_shift[WORD_WIDTH-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active   <= 1'b0;
            sck      <= 1'b0;
            done     <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active   <= 1'b1;
                sck      <= 1'b0;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                tx_shift <= data_in;
            end else if (active) begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt <= '0;
                    if (!sck) begin
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[WORD_WIDTH-2:0], miso};
                    end else begin
                        sck <= 1'b0;
                        if (bit_cnt == BIT_W'(WORD_WIDTH - 1)) begin
                            active   <= 1'b0;
                            done     <= 1'b1;
                            data_out <= rx_shift;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/myo_spi_poller.sv
// Round-robin SPI poller for the motor boards. Each enabled board gets one frame
// of WORDS_PER_FRAME full-duplex words, and frames are separated by an idle gap.
module myo_spi_poller
    import myo_spi_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 9,
    parameter int WORD_WIDTH       = 16,
    parameter int WORDS_PER_FRAME  = 12,
    parameter int CLK_DIV          = 8,
    parameter int GAP_CYCLES       = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [NUMBER_OF_MOTORS-1:0]            motor_mask,
    input  logic                                   power_sense_n,
    output logic                                   tx_req,
    output logic [width_of(NUMBER_OF_MOTORS)-1:0]  tx_motor,
    output logic [width_of(WORDS_PER_FRAME)-1:0]   tx_idx,
    input  logic [WORD_WIDTH-1:0]                  tx_word,
    output logic                                   rx_valid,
    output logic [WORD_WIDTH-1:0]                  rx_word,
    output logic [width_of(NUMBER_OF_MOTORS)-1:0]  rx_motor,
    output logic [width_of(WORDS_PER_FRAME)-1:0]   rx_idx,
    output logic                                   frame_done,
    output logic                                   busy,
    output logic                                   power_fault,
    output logic                                   sck,
    output logic                                   mosi,
    input  logic                                   miso,
    output logic [NUMBER_OF_MOTORS-1:0]            ss_n
);

    localparam int MOTOR_W = width_of(NUMBER_OF_MOTORS);
    localparam int IDX_W   = width_of(WORDS_PER_FRAME);
    localparam int HOLD_W  = width_of(CLK_DIV);
    localparam int GAP_W   = width_of(GAP_CYCLES);

    state_t             state, next_state;
    logic [MOTOR_W-1:0] motor, pick;
    logic               ptr_valid, found;
    logic [IDX_W-1:0]   word_idx;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               load_phase, start, shift_done;
    logic               can_start, hold_end, gap_end, last_word;
    int                 cand;

    assign can_start = enable && !power_sense_n && (|motor_mask);
    assign hold_end  = (hold_cnt == HOLD_W'(CLK_DIV - 1));
    assign gap_end   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign last_word = (word_idx == IDX_W'(WORDS_PER_FRAME - 1));

    // Before the first selection ptr_valid is low and the search begins at bit 0.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
            cand = ptr_valid ? int'(motor) + 1 + i : i;
            if (cand >= NUMBER_OF_MOTORS) cand = cand - NUMBER_OF_MOTORS;
            if (!found && motor_mask[MOTOR_W'(cand)]) begin
                pick  = MOTOR_W'(cand);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (can_start) next_state = SELECT;
            SELECT:   if (hold_end) next_state = LOAD;
            LOAD:     if (load_phase) next_state = SHIFT;
            SHIFT:    if (shift_done) next_state = last_word ? DESELECT : LOAD;
            DESELECT: if (hold_end) next_state = GAP;
            GAP:      if (gap_end) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            motor       <= '0;
            ptr_valid   <= 1'b0;
            word_idx    <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            load_phase  <= 1'b0;
            power_fault <= 1'b0;
        end else begin
            power_fault <= power_sense_n;
            hold_cnt    <= ((state == SELECT || state == DESELECT) && !hold_end) ? hold_cnt + 1'b1 : '0;
            gap_cnt     <= (state == GAP && !gap_end) ? gap_cnt + 1'b1 : '0;
            load_phase  <= (state == LOAD) && !load_phase;
            if (state == IDLE && can_start) begin
                motor     <= pick;
                ptr_valid <= 1'b1;
                word_idx  <= '0;
            end else if (state == SHIFT && shift_done && !last_word) begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    // tx_word is captured on the second LOAD cycle, one clock after the tx_req pulse.
    always_comb begin
        tx_req     = (state == LOAD) && !load_phase;
        start      = (state == LOAD) && load_phase;
        busy       = (state != IDLE);
        frame_done = (state == GAP) && (gap_cnt == '0);
        rx_valid   = shift_done;
        tx_motor   = motor;
        tx_idx     = word_idx;
        rx_motor   = motor;
        rx_idx     = word_idx;
        ss_n       = '1;
        if (state == SELECT || state == LOAD || state == SHIFT || state == DESELECT)
            ss_n[motor] = 1'b0;
    end

    myo_spi_shifter #(
        .WORD_WIDTH (WORD_WIDTH),
        .CLK_DIV    (CLK_DIV)
    ) shifter (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .data_in  (tx_word),
        .miso     (miso),
        .sck      (sck),
        .mosi     (mosi),
        .done     (shift_done),
        .data_out (rx_word)
    );

endmodule

// File: tb/tb_myo_spi_poller.sv
// Directed and randomized checks of the poller against a word-level model of
// round-robin selection and per-motor SPI slave data.
module tb_myo_spi_poller;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int F       = 2;
    localparam int DIV     = 2;
    localparam int GAP     = 3;
    localparam int TIMEOUT = 2000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [N-1:0] motor_mask = '0;
    logic         power_sense_n = 1'b0;
    logic         tx_req;
    logic [1:0]   tx_motor;
    logic [0:0]   tx_idx;
    logic [W-1:0] tx_word;
    logic         rx_valid;
    logic [W-1:0] rx_word;
    logic [1:0]   rx_motor;
    logic [0:0]   rx_idx;
    logic         frame_done, busy, power_fault, sck, mosi, miso;
    logic [N-1:0] ss_n;

    logic [W-1:0] tx_mem   [N][F];
    logic [W-1:0] resp_mem [N][F];
    int miso_mode  = 1;
    int tests      = 0;
    int failures   = 0;
    int last_motor = -1;

    int k = 0, rises = 0, cyc = 0, last_rise = 0, bad_period = 0, bad_mosi = 0;
    logic         sck_prev = 1'b0, mosi_prev = 1'b0;
    logic [W-1:0] cap = '0;
    logic [W-1:0] resp_word;
    logic         resp_bit;

    always #5 clock = ~clock;

    myo_spi_poller #(
        .NUMBER_OF_MOTORS (N),
        .WORD_WIDTH       (W),
        .WORDS_PER_FRAME  (F),
        .CLK_DIV          (DIV),
        .GAP_CYCLES       (GAP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .motor_mask    (motor_mask),
        .power_sense_n (power_sense_n),
        .tx_req        (tx_req),
        .tx_motor      (tx_motor),
        .tx_idx        (tx_idx),
        .tx_word       (tx_word),
        .rx_valid      (rx_valid),
        .rx_word       (rx_word),
        .rx_motor      (rx_motor),
        .rx_idx        (rx_idx),
        .frame_done    (frame_done),
        .busy          (busy),
        .power_fault   (power_fault),
        .sck           (sck),
        .mosi          (mosi),
        .miso          (miso),
        .ss_n          (ss_n)
    );

    // Word source and slave: the slave presents bit k of its reply, advancing on each sck fall.
    assign tx_word   = tx_mem[tx_motor][tx_idx];
    assign resp_word = resp_mem[tx_motor][tx_idx];
    assign resp_bit  = (k < W) ? resp_word[W-1-k] : 1'b0;
    assign miso      = (miso_mode == 0) ? resp_bit :
                       (miso_mode == 1) ? mosi :
                       (miso_mode == 2);

    always @(negedge clock) begin
        cyc++;
        if (tx_req) begin
            k     = 0;
            rises = 0;
        end else begin
            if (!sck_prev && sck) begin
                if (rises > 0 && (cyc - last_rise) != 2 * DIV) bad_period++;
                rises++;
                last_rise = cyc;
                cap = {cap[W-2:0], mosi};
            end
            if (sck_prev && !sck) k++;
        end
        if (sck_prev && sck && mosi !== mosi_prev) bad_mosi++;
        sck_prev  = sck;
        mosi_prev = mosi;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] mask);
        int c;
        for (int i = 1; i <= N; i++) begin
            c = (last_motor + i + N) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] expected_rx(input int m, input int i);
        case (miso_mode)
            0:       return resp_mem[m][i];
            1:       return tx_mem[m][i];
            2:       return '1;
            default: return '0;
        endcase
    endfunction

    task automatic fill(input bit constant);
        for (int m = 0; m < N; m++)
            for (int i = 0; i < F; i++) begin
                tx_mem[m][i]   = constant ? 16'hA5C3 : 16'($urandom);
                resp_mem[m][i] = 16'($urandom);
            end
    endtask

    task automatic applyStimulus(input int m, input bit drop);
        int t;
        logic [N-1:0] exp_ss;
        exp_ss = ~(N'(1) << m);
        t = 0;
        while (ss_n === '1 && t < TIMEOUT) begin @(negedge clock); t++; end
        check("select", ss_n, exp_ss);
        if (drop) begin
            t = 0;
            while (tx_req !== 1'b1 && t < TIMEOUT) begin @(negedge clock); t++; end
            enable = 1'b0;
        end
        for (int i = 0; i < F; i++) begin
            t = 0;
            while (rx_valid !== 1'b1 && t < TIMEOUT) begin @(negedge clock); t++; end
            check("rx_valid", rx_valid, 1);
            check("rx_motor", rx_motor, m);
            check("rx_idx", rx_idx, i);
            check("rx_word", rx_word, expected_rx(m, i));
            check("mosi_word", cap, tx_mem[m][i]);
            check("sck_rises", rises, W);
            check("ss_hold", ss_n, exp_ss);
            @(negedge clock);
        end
        t = 0;
        while (frame_done !== 1'b1 && t < TIMEOUT) begin @(negedge clock); t++; end
        check("frame_done", frame_done, 1);
        check("ss_release", ss_n, {N{1'b1}});
        last_motor = m;
    endtask

    task automatic checkOutput(input string tag, input int cycles);
        int active;
        active = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            if (busy !== 1'b0 || ss_n !== '1) active++;
        end
        check(tag, active, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t, spurious;
        fill(1'b1);
        repeat (3) @(negedge clock);
        check("rst_ss_n", ss_n, {N{1'b1}});
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_power_fault", power_fault, 0);
        check("rst_rx_word", rx_word, 0);
        reset = 1'b0;

        motor_mask = 4'b1111;
        enable     = 1'b1;
        for (int f = 0; f < 5; f++) applyStimulus(rr_next(motor_mask), 1'b0);

        motor_mask = 4'b0101;
        for (int f = 0; f < 3; f++) applyStimulus(rr_next(motor_mask), 1'b0);

        miso_mode = 0;
        fill(1'b0);
        for (int f = 0; f < 8; f++) begin
            motor_mask = 4'($urandom_range(1, 15));
            applyStimulus(rr_next(motor_mask), 1'b0);
        end

        motor_mask = 4'b1111;
        miso_mode  = 2;
        applyStimulus(rr_next(motor_mask), 1'b0);
        miso_mode  = 3;
        applyStimulus(rr_next(motor_mask), 1'b0);
        miso_mode  = 0;

        motor_mask = 4'b0000;
        repeat (GAP + 2) @(negedge clock);
        checkOutput("mask_zero_idle", 50);

        motor_mask = 4'b0010;
        applyStimulus(rr_next(motor_mask), 1'b1);
        repeat (GAP + 2) @(negedge clock);
        checkOutput("enable_drop_idle", 40);

        reset         = 1'b1;
        power_sense_n = 1'b1;
        enable        = 1'b1;
        motor_mask    = 4'b1111;
        last_motor    = -1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("power_fault_set", power_fault, 1);
        checkOutput("power_absent_idle", 40);
        power_sense_n = 1'b0;
        applyStimulus(rr_next(motor_mask), 1'b0);
        check("power_fault_clear", power_fault, 0);
        applyStimulus(rr_next(motor_mask), 1'b0);

        t = 0;
        while (ss_n === '1 && t < TIMEOUT) begin @(negedge clock); t++; end
        check("abort_select", ss_n, 4'b1011);
        t = 0;
        while (sck !== 1'b1 && t < TIMEOUT) begin @(negedge clock); t++; end
        check("abort_in_shift", sck, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_ss_n", ss_n, {N{1'b1}});
        check("abort_sck", sck, 0);
        check("abort_busy", busy, 0);
        spurious = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (rx_valid !== 1'b0 || frame_done !== 1'b0) spurious++;
        end
        check("abort_no_pulses", spurious, 0);
        reset      = 1'b0;
        last_motor = -1;
        applyStimulus(rr_next(motor_mask), 1'b0);

        check("sck_period", bad_period, 0);
        check("mosi_stable_high", bad_mosi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
